// File: rtl/router_pkg.sv
// Shared types and constants for the packet router: port count, FSM states, header offsets, parity helper.
package router_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DA_IDX    = 0;
    localparam int SA_IDX    = 1;
    localparam int LEN_IDX   = 2;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SA      = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        PARITY  = 3'd4,
        DROP    = 3'd5
    } state_t;

    function automatic byte_t next_parity(input byte_t acc, input byte_t b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/pkt_router_if.sv
// Packet router bus: byte-serial ingress, address config, four drain ports and error flags.
interface pkt_router_if;
    import router_pkg::*;

    logic        packet_valid;
    byte_t       data;
    logic        mem_en;
    logic        mem_rd_wr;
    logic [1:0]  mem_add;
    byte_t       mem_data;
    logic        ready_0, ready_1, ready_2, ready_3;
    logic        read_0, read_1, read_2, read_3;
    byte_t       data_0, data_1, data_2, data_3;
    logic        err_parity;
    logic        err_len;
    logic [3:0]  err_ovf;

    modport master (
        output packet_valid, data, mem_en, mem_rd_wr, mem_add, mem_data,
        output read_0, read_1, read_2, read_3,
        input  ready_0, ready_1, ready_2, ready_3,
        input  data_0, data_1, data_2, data_3,
        input  err_parity, err_len, err_ovf
    );

    modport slave (
        input  packet_valid, data, mem_en, mem_rd_wr, mem_add, mem_data,
        input  read_0, read_1, read_2, read_3,
        output ready_0, ready_1, ready_2, ready_3,
        output data_0, data_1, data_2, data_3,
        output err_parity, err_len, err_ovf
    );
endinterface

// File: rtl/router_port_fifo.sv
// Per-port byte FIFO with wrap-bit pointers; a read and a write in one cycle both occur, even when full.
module router_port_fifo
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 64
) (
    input  logic  clock,
    input  logic  reset_n,
    input  logic  wr_en,
    input  byte_t wr_data,
    input  logic  rd_en,
    output byte_t rd_data,
    output logic  empty,
    output logic  full
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_r, rd_ptr_r;
    byte_t       mem_r [FIFO_DEPTH];
    logic        do_rd_s, do_wr_s;

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_rd_s = rd_en && !empty;
    assign do_wr_s = wr_en && (!full || do_rd_s);

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Pointer advance and registered read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            rd_data  <= 8'h00;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
                rd_data  <= mem_r[rd_ptr_r[AW-1:0]];
            end
        end
    end
endmodule

// File: rtl/pkt_router.sv
// Packet router top: parse FSM, port-address registers, error flags, four output FIFOs.
// Optional parity check enabled by defining ROUTER_PARITY_CHK_EN.
module pkt_router
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    pkt_router_if.slave  bus
);
    state_t                 state_r, state_s;
    logic [1:0]             dest_r;
    byte_t                  len_cnt_r;
    logic                   last_par_r;
    byte_t                  addr_r [NUM_PORTS];
    logic                   err_len_r;
    logic [NUM_PORTS-1:0]   err_ovf_r;

    logic                   match_s;
    logic [1:0]             match_idx_s;
    logic                   accept_s;
    logic                   err_len_s;
    logic [1:0]             wr_port_s;
    logic [NUM_PORTS-1:0]   wr_en_s, rd_en_s, empty_s, full_s, ovf_s;
    byte_t                  rd_data_s [NUM_PORTS];

    // Destination lookup; descending scan so the lowest matching index wins.
    always_comb begin
        match_s     = 1'b0;
        match_idx_s = 2'd0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.data == addr_r[i]) begin
                match_s     = 1'b1;
                match_idx_s = 2'(i);
            end else begin
                match_s     = match_s;
                match_idx_s = match_idx_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; last_par_r marks the cycle straight after a parity byte.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!bus.packet_valid) state_s = IDLE;
                else if (last_par_r)   state_s = DROP;
                else if (match_s)      state_s = SA;
                else                   state_s = DROP;
            end
            SA:      state_s = bus.packet_valid ? LEN : IDLE;
            LEN: begin
                if (!bus.packet_valid)         state_s = IDLE;
                else if (bus.data == 8'd0)     state_s = PARITY;
                else                           state_s = PAYLOAD;
            end
            PAYLOAD: begin
                if (!bus.packet_valid)         state_s = IDLE;
                else if (len_cnt_r == 8'd1)    state_s = PARITY;
                else                           state_s = PAYLOAD;
            end
            PARITY:  state_s = IDLE;
            DROP:    state_s = bus.packet_valid ? DROP : IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: FIFO write strobe, target port and framing error.
    always_comb begin
        accept_s  = 1'b0;
        err_len_s = 1'b0;
        wr_port_s = dest_r;
        case (state_r)
            IDLE: begin
                accept_s  = bus.packet_valid && !last_par_r && match_s;
                err_len_s = bus.packet_valid && last_par_r;
                wr_port_s = match_idx_s;
            end
            SA, LEN, PAYLOAD, PARITY: begin
                accept_s  = bus.packet_valid;
                err_len_s = !bus.packet_valid;
            end
            default: begin
                accept_s  = 1'b0;
                err_len_s = 1'b0;
            end
        endcase
    end

    // Datapath registers: address table, destination, length counter, error flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PORTS; i++) addr_r[i] <= 8'(i);
            dest_r     <= 2'd0;
            len_cnt_r  <= 8'd0;
            last_par_r <= 1'b0;
            err_len_r  <= 1'b0;
            err_ovf_r  <= '0;
        end else begin
            if (bus.mem_en && bus.mem_rd_wr) addr_r[bus.mem_add] <= bus.mem_data;
            if (state_r == IDLE && accept_s) dest_r <= match_idx_s;
            if (bus.packet_valid && state_r == LEN)          len_cnt_r <= bus.data;
            else if (bus.packet_valid && state_r == PAYLOAD) len_cnt_r <= len_cnt_r - 8'd1;
            else                                             len_cnt_r <= len_cnt_r;
            last_par_r <= (state_r == PARITY) && bus.packet_valid;
            err_len_r  <= err_len_s;
            err_ovf_r  <= err_ovf_r | ovf_s;
        end
    end

`ifdef ROUTER_PARITY_CHK_EN
    byte_t par_acc_r;
    logic  err_parity_r;

    // Running XOR of DA..last payload byte, checked against the parity byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            par_acc_r    <= 8'h00;
            err_parity_r <= 1'b0;
        end else begin
            if (state_r == IDLE && bus.packet_valid)
                par_acc_r <= bus.data;
            else if (bus.packet_valid && (state_r == SA || state_r == LEN || state_r == PAYLOAD))
                par_acc_r <= next_parity(par_acc_r, bus.data);
            else
                par_acc_r <= par_acc_r;
            err_parity_r <= (state_r == PARITY) && bus.packet_valid && (bus.data != par_acc_r);
        end
    end
    assign bus.err_parity = err_parity_r;
`else
    assign bus.err_parity = 1'b0;
`endif

    assign rd_en_s = {bus.read_3, bus.read_2, bus.read_1, bus.read_0};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign wr_en_s[g] = accept_s && (wr_port_s == 2'(g));
        assign ovf_s[g]   = wr_en_s[g] && full_s[g] && !rd_en_s[g];

        router_port_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .wr_en   (wr_en_s[g]),
            .wr_data (bus.data),
            .rd_en   (rd_en_s[g]),
            .rd_data (rd_data_s[g]),
            .empty   (empty_s[g]),
            .full    (full_s[g])
        );
    end

    assign bus.ready_0 = !empty_s[0];
    assign bus.ready_1 = !empty_s[1];
    assign bus.ready_2 = !empty_s[2];
    assign bus.ready_3 = !empty_s[3];
    assign bus.data_0  = rd_data_s[0];
    assign bus.data_1  = rd_data_s[1];
    assign bus.data_2  = rd_data_s[2];
    assign bus.data_3  = rd_data_s[3];
    assign bus.err_len = err_len_r;
    assign bus.err_ovf = err_ovf_r;
endmodule

// File: tb/tb_pkt_router.sv
// Directed testbench for pkt_router (FIFO_DEPTH=8) with per-port scoreboard queues.
module tb_pkt_router;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pkt_router_if bus();

    pkt_router #(.FIFO_DEPTH(DEPTH)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int len_pulses = 0;
    int par_pulses = 0;
    int base_len, base_par;

    logic [7:0] exp_q [4][$];
    logic [7:0] addr_m [4];
    logic [3:0] ovf_m;

    // Count error pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.err_len === 1'b1) len_pulses <= len_pulses + 1;
        if (bus.err_parity === 1'b1) par_pulses <= par_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int p);
        case (p)
            0: return bus.ready_0;
            1: return bus.ready_1;
            2: return bus.ready_2;
            default: return bus.ready_3;
        endcase
    endfunction

    function automatic logic [7:0] get_data(input int p);
        case (p)
            0: return bus.data_0;
            1: return bus.data_1;
            2: return bus.data_2;
            default: return bus.data_3;
        endcase
    endfunction

    task automatic set_read(input int p, input logic v);
        case (p)
            0: bus.read_0 = v;
            1: bus.read_1 = v;
            2: bus.read_2 = v;
            default: bus.read_3 = v;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            addr_m[i] = 8'(i);
        end
        ovf_m = 4'b0000;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [7:0] val);
        bus.mem_en = 1'b1; bus.mem_rd_wr = 1'b1; bus.mem_add = idx; bus.mem_data = val;
        tick();
        bus.mem_en = 1'b0; bus.mem_rd_wr = 1'b0;
        addr_m[idx] = val;
    endtask

    // n_drive < 0 drives the whole packet; extra adds trailing bytes after PARITY.
    task automatic send_pkt(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len,
                            input int n_drive, input logic [7:0] par_xor, input int extra);
        logic [7:0] pkt [$];
        logic [7:0] par;
        int dest, n;
        pkt.push_back(da); pkt.push_back(sa); pkt.push_back(len);
        for (int i = 0; i < int'(len); i++) pkt.push_back(8'hA1 + 8'(i));
        par = 8'h00;
        foreach (pkt[i]) par = par ^ pkt[i];
        pkt.push_back(par ^ par_xor);
        n = (n_drive < 0) ? pkt.size() : n_drive;
        dest = -1;
        for (int i = 3; i >= 0; i--) if (addr_m[i] == da) dest = i;
        for (int i = 0; i < n; i++) begin
            if (dest >= 0) begin
                if (exp_q[dest].size() < DEPTH) exp_q[dest].push_back(pkt[i]);
                else ovf_m[dest] = 1'b1;
            end
            bus.packet_valid = 1'b1; bus.data = pkt[i];
            tick();
        end
        for (int i = 0; i < extra; i++) begin
            bus.packet_valid = 1'b1; bus.data = 8'hEE;
            tick();
        end
        bus.packet_valid = 1'b0; bus.data = 8'h00;
        tick();
        tick();
    endtask

    task automatic drain(input int p, input string tag);
        int n;
        logic [7:0] e;
        n = exp_q[p].size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_ready"}, 32'(get_ready(p)), 32'd1);
            set_read(p, 1'b1);
            tick();
            set_read(p, 1'b0);
            e = exp_q[p].pop_front();
            chk({tag, "_data"}, 32'(get_data(p)), 32'(e));
        end
        chk({tag, "_empty"}, 32'(get_ready(p)), 32'd0);
    endtask

    task automatic chk_all_empty(input string tag);
        chk(tag, 32'({bus.ready_3, bus.ready_2, bus.ready_1, bus.ready_0}), 32'd0);
    endtask

    task automatic mark();
        base_len = len_pulses;
        base_par = par_pulses;
    endtask

    initial begin
        bus.packet_valid = 1'b0; bus.data = 8'h00;
        bus.mem_en = 1'b0; bus.mem_rd_wr = 1'b0; bus.mem_add = 2'd0; bus.mem_data = 8'h00;
        bus.read_0 = 1'b0; bus.read_1 = 1'b0; bus.read_2 = 1'b0; bus.read_3 = 1'b0;
        model_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        chk_all_empty("reset_ready");
        chk("reset_data", 32'({bus.data_3, bus.data_2, bus.data_1, bus.data_0}), 32'd0);
        chk("reset_errs", 32'({bus.err_parity, bus.err_len}), 32'd0);
        chk("reset_ovf", 32'(bus.err_ovf), 32'd0);

        mark();
        send_pkt(8'h02, 8'h10, 8'd3, -1, 8'h00, 0);
        chk("p2_ready_other", 32'({bus.ready_3, bus.ready_1, bus.ready_0}), 32'd0);
        drain(2, "p2");
        chk("p2_err_len", 32'(len_pulses - base_len), 32'd0);
        chk("p2_err_par", 32'(par_pulses - base_par), 32'd0);

        cfg_write(2'd1, 8'h55);
        mark();
        send_pkt(8'h55, 8'h20, 8'd0, -1, 8'h00, 0);
        chk("p1_count", 32'(exp_q[1].size()), 32'd4);
        drain(1, "p1");
        send_pkt(8'h77, 8'h20, 8'd2, -1, 8'h00, 0);
        chk_all_empty("drop_ready");
        chk("drop_err_len", 32'(len_pulses - base_len), 32'd0);

        mark();
        send_pkt(8'h03, 8'h30, 8'd2, -1, 8'h01, 0);
`ifdef ROUTER_PARITY_CHK_EN
        chk("par_pulse", 32'(par_pulses - base_par), 32'd1);
`else
        chk("par_pulse", 32'(par_pulses - base_par), 32'd0);
`endif
        drain(3, "par");

        mark();
        send_pkt(8'h00, 8'h40, 8'd6, -1, 8'h00, 0);
        chk("ovf_flag", 32'(bus.err_ovf), 32'(ovf_m));
        chk("ovf_model", 32'(ovf_m), 32'b0001);
        drain(0, "ovf");
        send_pkt(8'h00, 8'h41, 8'd1, -1, 8'h00, 0);
        drain(0, "ovf_next");
        chk("ovf_sticky", 32'(bus.err_ovf), 32'b0001);

        mark();
        send_pkt(8'h02, 8'h50, 8'd5, 7, 8'h00, 0);
        chk("trunc_err_len", 32'(len_pulses - base_len), 32'd1);
        chk("trunc_count", 32'(exp_q[2].size()), 32'd7);
        send_pkt(8'h55, 8'h51, 8'd2, -1, 8'h00, 0);
        drain(2, "trunc");
        drain(1, "trunc_next");

        mark();
        send_pkt(8'h03, 8'h60, 8'd1, -1, 8'h00, 2);
        chk("excess_err_len", 32'(len_pulses - base_len), 32'd1);
        drain(3, "excess");

        bus.packet_valid = 1'b1;
        bus.data = 8'h02; tick();
        bus.data = 8'h70; tick();
        bus.data = 8'h04; tick();
        bus.data = 8'hB1; tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all_empty("rst_ready");
        chk("rst_data", 32'({bus.data_3, bus.data_2, bus.data_1, bus.data_0}), 32'd0);
        chk("rst_ovf", 32'(bus.err_ovf), 32'd0);
        bus.packet_valid = 1'b0; bus.data = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        send_pkt(8'h01, 8'h80, 8'd2, -1, 8'h00, 0);
        drain(1, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
